// File: rtl/dense_mac_array.sv
// Dense/1x1-conv MAC array: EngineCount engines share one activation per beat, accumulate on a bias, requantise.
// Optional DENSE_ROUND_EN adds round-half-up ahead of the requantisation shift (default build truncates).
module dense_mac_array #(
    parameter int N           = 16,
    parameter int EngineCount = 64,
    parameter int AccWidth    = 40,
    parameter int LenBits     = 12,
    parameter int ShiftBits   = 6
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [LenBits-1:0]              cfg_len_i,
    input  logic [ShiftBits-1:0]            cfg_shift_i,
    input  logic                            cfg_relu_i,
    input  logic [EngineCount-1:0][N-1:0]   bias_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [N-1:0]                    act_i,
    input  logic [EngineCount-1:0][N-1:0]   weight_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [EngineCount-1:0][N-1:0]   dense_o,
    output logic                            busy_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    localparam int RW     = AccWidth + 1;
    localparam int MAX_SH = AccWidth - 1;
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-N+1){1'b1}}, {(N-1){1'b0}}};

    state_t                      state_q, state_nxt;
    logic [LenBits-1:0]          len_q, cnt_q;
    logic [ShiftBits-1:0]        shift_q, shift_eff;
    logic                        relu_q, relu_eff;
    logic signed [AccWidth-1:0]  acc_q   [EngineCount];
    logic signed [AccWidth-1:0]  acc_nxt [EngineCount];
    logic [EngineCount-1:0][N-1:0] dense_nxt;
    logic                        fire, last_beat, start_job, enter_out;

    // Shift, round, saturate and optionally clamp one accumulator to an N-bit result.
    function automatic logic [N-1:0] requant(input logic signed [AccWidth-1:0] acc,
                                             input logic [ShiftBits-1:0] shift,
                                             input logic relu);
        int sh;
        logic signed [RW-1:0] ext, r;
        sh  = (int'(shift) > MAX_SH) ? MAX_SH : int'(shift);
        ext = RW'(acc);
`ifdef DENSE_ROUND_EN
        if (sh > 0) ext = ext + (RW'(1) << (sh - 1));
`else
`endif
        r = ext >>> sh;
        if (r > SAT_MAX)      r = SAT_MAX;
        else if (r < SAT_MIN) r = SAT_MIN;
        if (relu && r < 0)    r = '0;
        return r[N-1:0];
    endfunction

    assign fire      = in_valid_i && in_ready_o;
    assign start_job = (state_q == IDLE) && start_i;
    assign last_beat = fire && (cnt_q == len_q - LenBits'(1));
    assign enter_out = (state_nxt == OUT) && (state_q != OUT);
    // On the start cycle the config is not yet latched, so requantise with the live inputs.
    assign shift_eff = (state_q == IDLE) ? cfg_shift_i : shift_q;
    assign relu_eff  = (state_q == IDLE) ? cfg_relu_i  : relu_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // NOTE: defaulting the output at the top of every always_comb keeps each path assigned, so no latch.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:  if (start_i) state_nxt = (cfg_len_i == '0) ? OUT : ACCUM;
            ACCUM: if (last_beat) state_nxt = OUT;
            OUT:   if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ACCUM);
        out_valid_o = (state_q == OUT);
        busy_o      = (state_q != IDLE);
    end

    always_comb begin
        logic signed [2*N-1:0] prod;
        prod = '0;
        for (int i = 0; i < EngineCount; i++) begin
            acc_nxt[i] = acc_q[i];
            prod       = $signed(act_i) * $signed(weight_i[i]);
            if (start_job)
                acc_nxt[i] = AccWidth'($signed(bias_i[i]));
            else if (fire)
                acc_nxt[i] = acc_q[i] + AccWidth'(prod);
            dense_nxt[i] = requant(acc_nxt[i], shift_eff, relu_eff);
        end
    end

    // NOTE: the accumulator array is a bank of flops that must read zero after reset, so it is cleared in a loop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            dense_o <= '0;
            for (int i = 0; i < EngineCount; i++) acc_q[i] <= '0;
        end else begin
            if (start_job) begin
                len_q   <= cfg_len_i;
                shift_q <= cfg_shift_i;
                relu_q  <= cfg_relu_i;
                cnt_q   <= '0;
            end else if (fire) begin
                cnt_q <= cnt_q + LenBits'(1);
            end
            for (int i = 0; i < EngineCount; i++) acc_q[i] <= acc_nxt[i];
            if (enter_out) dense_o <= dense_nxt;
        end
    end

endmodule

// File: tb/tb_dense_mac_array.sv
// Directed scoreboard bench for dense_mac_array with four engines; expected vectors are queued at job start.
module tb_dense_mac_array;

    localparam int N  = 16;
    localparam int EC = 4;
    localparam int LB = 12;
    localparam int SB = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [LB-1:0]        cfg_len = '0;
    logic [SB-1:0]        cfg_shift = '0;
    logic                 cfg_relu = 1'b0;
    logic [EC-1:0][N-1:0] bias = '0;
    logic [EC-1:0][N-1:0] weight = '0;
    logic [EC-1:0][N-1:0] dense;
    logic [N-1:0]         act = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready, out_valid, busy;
    logic                 out_ready = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          fires = 0;
    logic [63:0] exp_q[$];

    dense_mac_array #(.N(N), .EngineCount(EC), .AccWidth(40), .LenBits(LB), .ShiftBits(SB)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .cfg_len_i(cfg_len), .cfg_shift_i(cfg_shift), .cfg_relu_i(cfg_relu), .bias_i(bias),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .act_i(act), .weight_i(weight),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .dense_o(dense), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (in_valid && in_ready) fires <= fires + 1;

    function automatic logic [63:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {e3[15:0], e2[15:0], e1[15:0], e0[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int len, input int shift, input logic relu,
                             input logic [63:0] b, input bit push, input logic [63:0] expv);
        @(negedge clk);
        cfg_len   = LB'(len);
        cfg_shift = SB'(shift);
        cfg_relu  = relu;
        bias      = b;
        start     = 1'b1;
        if (push) exp_q.push_back(expv);
        @(negedge clk);
        start     = 1'b0;
        cfg_len   = '0;
        cfg_shift = '1;
        cfg_relu  = ~relu;
        bias      = '1;
    endtask

    task automatic beat(input int a, input logic [63:0] w);
        act      = N'(a);
        weight   = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int n = 0;
        logic [63:0] expv;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " sb_depth"}, 64'(exp_q.size()), 64'd1);
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        check({tag, " dense"}, 64'(dense), expv);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, " idle_after"}, {62'd0, busy, out_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        int f0;

        repeat (2) @(negedge clk);
        check("reset ctl", {61'd0, in_ready, out_valid, busy}, 64'd0);
        check("reset dense", 64'(dense), 64'd0);
        rst = 1'b0;

        // Basic job with backpressure and an ignored start during OUT
        start_job(3, 0, 1'b0, pack4(0, 1, -1, 5), 1'b1, pack4(18, 19, 17, 23));
        repeat (3) beat(2, pack4(3, 3, 3, 3));
        check("A latency", {62'd0, out_valid, in_ready}, 64'b10);
        held = 64'(dense);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            @(negedge clk);
            check($sformatf("A hold%0d dense", i), 64'(dense), held);
            check($sformatf("A hold%0d ctl", i), {61'd0, out_valid, in_ready, busy}, 64'b101);
        end
        collect("A");

        // Zero-length job: result is the requantised bias
`ifdef DENSE_ROUND_EN
        start_job(0, 2, 1'b0, pack4(100, -100, 7, 0), 1'b1, pack4(25, -25, 2, 0));
`else
        start_job(0, 2, 1'b0, pack4(100, -100, 7, 0), 1'b1, pack4(25, -25, 1, 0));
`endif
        check("B latency", 64'(out_valid), 64'd1);
        collect("B");

        // Saturation and ReLU
        start_job(2, 0, 1'b0, '0, 1'b1, pack4(32767, 32767, 32767, 32767));
        repeat (2) beat(32767, pack4(32767, 32767, 32767, 32767));
        collect("C pos");
        start_job(2, 0, 1'b0, '0, 1'b1, pack4(-32768, -32768, -32768, -32768));
        repeat (2) beat(32767, pack4(-32767, -32767, -32767, -32767));
        collect("C neg");
        start_job(2, 0, 1'b1, '0, 1'b1, pack4(0, 0, 0, 0));
        repeat (2) beat(32767, pack4(-32767, -32767, -32767, -32767));
        collect("C relu");

        // Gapped beats, per-engine weights; in_valid held high in OUT must not add beats
        start_job(4, 1, 1'b0, '0, 1'b1, pack4(53, -106, 159, -212));
        f0 = fires;
        beat(5, pack4(1, -2, 3, -4));   @(negedge clk);
        beat(-6, pack4(1, -2, 3, -4));  @(negedge clk);
        beat(7, pack4(1, -2, 3, -4));   @(negedge clk);
        beat(100, pack4(1, -2, 3, -4));
        check("D latency", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        collect("D");
        check("D beats", 64'(fires - f0), 64'd4);

        // Reset mid-job, then a fresh job
        start_job(4, 0, 1'b0, pack4(9, 9, 9, 9), 1'b0, '0);
        repeat (2) beat(3, pack4(4, 4, 4, 4));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("E reset ctl", {61'd0, in_ready, out_valid, busy}, 64'd0);
        check("E reset dense", 64'(dense), 64'd0);
        start_job(1, 0, 1'b0, '0, 1'b1, pack4(1, 1, 1, 1));
        beat(1, pack4(1, 1, 1, 1));
        collect("E");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
